// File: rtl/lfsr_rng.sv
// Parametrised XNOR LFSR random-number peripheral with REQ/VALID/ACK word handshake,
// runtime seed load and lock-up recovery. Define RNG_FREERUN_EN to keep the LFSR shifting while idle.
module lfsr_rng #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h6B1CCA14),
  parameter int               OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ,
  input  logic             ACK,
  input  logic             SEED_LD,
  input  logic [WIDTH-1:0] SEED_IN,
  output logic [OUT_W-1:0] DATA,
  output logic             VALID,
  output logic             BUSY,
  output logic             LOCKUP
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef RNG_FREERUN_EN
  localparam bit FREERUN = 1'b1;
`else
  localparam bit FREERUN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} st_t;

  st_t              st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_shift;
  logic [OUT_W-1:0] data_q, data_d;
  logic             lock_q, lock_d;
  logic             busy_q;
  logic             adv;

  assign lfsr_shift = {lfsr_q[WIDTH-2:0], ~^(lfsr_q & TAPS)};

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    lfsr_d = lfsr_q;
    lock_d = lock_q;
    adv    = 1'b0;
    case (st_q)
      IDLE: begin
        adv = FREERUN;
        if (REQ) begin
          st_d  = SHIFT;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        adv = 1'b1;
        if (cnt_q == CW'(OUT_W - 1)) st_d = DONE;
        else                         cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        adv = FREERUN;
        if (ACK) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // Lock-up recovery replaces the shift and still counts as one in SHIFT.
    if (&lfsr_q) begin
      lfsr_d = SEED;
      lock_d = 1'b1;
    end else if (adv) begin
      lfsr_d = lfsr_shift;
    end
    if (st_q == SHIFT && st_d == DONE) data_d = lfsr_d[OUT_W-1:0];
    // Seed load overrides everything except the held DATA word.
    if (SEED_LD) begin
      st_d   = IDLE;
      cnt_d  = '0;
      data_d = data_q;
      lock_d = lock_q;
      if (&SEED_IN) begin
        lfsr_d = SEED;
        lock_d = 1'b1;
      end else begin
        lfsr_d = SEED_IN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      lfsr_q <= SEED;
      data_q <= '0;
      lock_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      lock_q <= lock_d;
      busy_q <= (st_d != IDLE);
    end
  end

  assign DATA   = data_q;
  assign VALID  = (st_q == DONE);
  assign BUSY   = busy_q;
  assign LOCKUP = lock_q;
endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised successor to the team's fixed 32-bit XNOR LFSR random generator. Width, taps, seed and output word size are parameters. Output words are delivered over a request/valid/acknowledge handshake, and each word contains OUT_W freshly shifted bits. The block also accepts a runtime seed load and detects and recovers from the XNOR lock-up state. It sits beside the CPU's I/O bus as a random-number peripheral; the bus wrapper drives REQ/ACK and reads DATA.

## Interface
- WIDTH, 32, LFSR state width (3..64)
- TAPS, 32'h80200003, feedback tap mask; bit i set = state[i] tapped (default taps 32,22,2,1)
- SEED, 32'h6B1CCA14, reset/recovery seed; must not be all-ones
- OUT_W, 8, bits per output word (1..WIDTH)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ  in  1  request one word; sampled only in IDLE
- ACK  in  1  consumer accepts DATA; meaningful only while VALID
- SEED_LD  in  1  load SEED_IN into state this cycle
- SEED_IN  in  WIDTH  runtime seed value
- DATA  out  OUT_W  output word
- VALID  out  1  DATA holds a complete word
- BUSY  out  1  high in SHIFT or DONE
- LOCKUP  out  1  sticky: lock-up state was detected and recovered

## Operation
- Feedback: fb = ~^(state & TAPS). A shift sets state <= {state[WIDTH-2:0], fb}.
- FSM states are IDLE, SHIFT and DONE. A bit counter cnt counts 0..OUT_W-1.
- IDLE: when REQ=1, go to SHIFT with cnt=0.
- SHIFT: shift once per cycle and increment cnt. After the OUT_W-th shift, go to DONE with DATA <= the new state[OUT_W-1:0].
- DONE: VALID=1 and DATA is held stable. When ACK=1, go to IDLE and drop VALID on the next edge.
- REQ is ignored outside IDLE. ACK is ignored outside DONE.
- Seed load has the highest priority and is honoured in any state:
  - state <= SEED_IN, FSM goes to IDLE, VALID goes low, DATA keeps its old value.
  - If SEED_IN is all-ones, SEED is loaded instead and LOCKUP is set.
  - If SEED_LD and REQ are high together, the load wins and the request is dropped.
- Lock-up: if state is all-ones at any clock edge without SEED_LD, the next state is SEED instead of a shift and LOCKUP is set. In SHIFT, that cycle still counts as a shift.
- LOCKUP clears only on reset.
- DATA is combinationally independent of the inputs; it is a register.

## Timing
- Reset values: state=SEED, FSM=IDLE, cnt=0, DATA=0, VALID=0, BUSY=0, LOCKUP=0.
- Latency: REQ seen high at edge n puts the FSM in SHIFT after edge n. The shifts occur at edges n+1..n+OUT_W, and VALID is high after edge n+OUT_W.
- Throughput: an ACK at edge m returns to IDLE after m. A REQ held high is taken at edge m+1, giving OUT_W+2 cycles per word when ACK is immediate.
- BUSY = (FSM != IDLE), registered with the FSM.
- Reset asserted mid-SHIFT or DONE clears everything asynchronously, and the partial word is lost. Deassertion is expected synchronised externally.
- OUT_W=1 works: a single SHIFT cycle.

## Configuration
- RNG_FREERUN_EN defined:
  - The LFSR also shifts on every IDLE and DONE cycle without SEED_LD, so the words depend on request timing.
  - DATA is still captured only at the end of SHIFT, and lock-up detection applies on every cycle.
- RNG_FREERUN_EN undefined: the state changes only during SHIFT, on seed load, or on lock-up recovery. The sequence is then purely a function of seed and request count.

## Test plan
- Reset and one shift: apply reset, then REQ one cycle, with defaults and OUT_W=1. Expect state after the first shift = 32'hD6399429 (fb=1), VALID high 1 cycle after entering SHIFT, and DATA=1'b1.
- Word sequence: defaults, 16 back-to-back REQ/ACK pairs. Expect each DATA to equal the low 8 bits of a reference-model state after 8k shifts, and VALID to stay high until ACK with DATA constant. Wait 5 cycles before ACK on one word.
- Seed load mid-SHIFT: assert SEED_LD with SEED_IN=32'h00000001 at cnt=3. Expect IDLE next cycle, VALID=0, and the next word generated from seed 1.
- Lock-up: SEED_LD with SEED_IN=32'hFFFFFFFF. Expect state=32'h6B1CCA14 and LOCKUP=1, with LOCKUP still 1 after 100 cycles and further words.
- Simultaneous events: REQ=1 with SEED_LD=1 in IDLE, which must give no SHIFT (BUSY stays 0). REQ during DONE must not restart shifting.
- Macro: build with RNG_FREERUN_EN, idle 10 cycles, then REQ. Expect state advanced by 10 before the word shifts; without the macro, state is unchanged while idle.
